deskew_ctrl: RTL and testbench
==============================

Name: deskew_ctrl

Overview:
- Lane-deskew sequencer for the 100GbE PCS receive path. Sits between the per-lane alignment-marker (AM) lock logic and the bank of N_LANES programmable deskew FIFOs.
- Measures the relative arrival time of the AM on each PCS lane.
- Computes a per-lane delay and issues a one-shot load of every FIFO read pointer.
- Then flags the lanes as deskewed. Re-acquires whenever any lane loses AM lock.

Parameters:
- N_LANES, 20, number of PCS lanes.
- MAX_SKEW, 16, maximum tolerated skew in valid cycles. Delays range 0..MAX_SKEW-1.
- NB_DELAY_COUNT, $clog2(MAX_SKEW), width of one per-lane delay value.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  clock enable. All state, counters and captures advance only when high.
- i_enable  in  1  deskew function enable. Low forces IDLE.
- i_am_lock  in  N_LANES  per-lane AM lock status, level.
- i_am_start  in  N_LANES  per-lane pulse: the AM block is present at that lane's FIFO input this cycle.
- o_fifo_write_enb  out  1  write enable to all deskew FIFOs.
- o_fifo_read_enb  out  1  read enable to all deskew FIFOs.
- o_set_fifo_delay  out  1  load strobe for the FIFO read pointers.
- o_fifo_delay  out  N_LANES*NB_DELAY_COUNT  per-lane delay. Lane k occupies bits [k*NB_DELAY_COUNT +: NB_DELAY_COUNT].
- o_deskew_done  out  1  all lanes aligned.
- o_invalid_skew  out  1  one-cycle pulse: measured skew exceeds MAX_SKEW-1.

Behaviour:
- Reset values:
  - State is IDLE.
  - All outputs are 0, including o_fifo_delay.
  - The arrival registers, the seen-mask and the skew counter are cleared.
- Global rule: if i_enable=0, or i_am_lock is not all-ones, the next state is IDLE from any state. This applies on any cycle, regardless of i_valid.
- IDLE:
  - o_fifo_write_enb=0, o_fifo_read_enb=0, o_deskew_done=0.
  - Go to WAIT_FIRST when i_enable=1 and all i_am_lock=1.
- WAIT_FIRST:
  - o_fifo_write_enb=1.
  - On a valid cycle with i_am_start!=0: record arrival=0 for each asserted lane, set seen-mask to i_am_start, set count=1, go to COUNT.
  - If i_am_start is all-ones in that cycle, go directly to SET with max_count=0.
- COUNT: on each valid cycle:
  - Every lane with i_am_start=1 and seen=0 records arrival=count and sets its seen bit.
  - A repeat pulse on an already-seen lane is ignored.
  - If seen|i_am_start becomes all-ones, latch max_count=count and go to SET.
  - Else, if count==MAX_SKEW-1, pulse o_invalid_skew for one cycle, clear the seen-mask and count, and go to WAIT_FIRST.
  - Else, increment count.
- SET:
  - o_fifo_delay[k] = max_count - arrival[k]. This is unsigned and never negative, because arrival[k] <= max_count.
  - o_fifo_delay is registered and held stable from SET onward until re-acquisition.
  - o_set_fifo_delay=1 is held until a valid cycle, then deasserted. On that valid cycle, go to LOCKED.
- LOCKED:
  - o_fifo_write_enb=1, o_fifo_read_enb=1, o_deskew_done=1.
  - Stay until the global rule fires. i_am_start is ignored.
- Latency:
  - Last lane's AM in valid cycle t: o_set_fifo_delay=1 in cycle t+1.
  - o_deskew_done=1 in the cycle after the valid SET cycle.
- Delay semantics: the lane that arrives first receives the largest delay; the last lane receives 0.
- Reset mid-operation: returns to the reset state on the next edge. A partially captured measurement is discarded.
- Count width: count is NB_DELAY_COUNT bits and never exceeds MAX_SKEW-1, so no wrap is possible.

Decomposition:
- Shared package pcs_deskew_pkg holds:
  - N_LANES and MAX_SKEW defaults.
  - The state encoding localparams: IDLE, WAIT_FIRST, COUNT, SET, LOCKED.
  - A delay-slice index helper.
- One natural sub-module: deskew_lane_capture.
  - Per lane: arrival register plus seen bit.
  - Inputs: clear, capture-enable, count.
  - Instantiated N_LANES times with a generate loop.

Test Plan:
- Zero skew, N_LANES=20: all locks high, i_am_start all-ones in one valid cycle -> o_set_fifo_delay next cycle, all o_fifo_delay=0, o_deskew_done one cycle later.
- Staggered arrival: lane0 at t, lanes1-18 at t+3, lane19 at t+7 -> delays: lane0=7, lanes1-18=4, lane19=0; set strobe at t+8.
- Skew overflow, MAX_SKEW=16: lane19 never arrives -> o_invalid_skew pulse exactly when count==15, return to WAIT_FIRST. A later good AM set completes deskew normally.
- i_valid gaps: valid toggles 1/0 during COUNT with the same arrival pattern as scenario 2 -> identical delays, with latency stretched only by the invalid cycles. o_set_fifo_delay is held through invalid cycles.
- Lock loss: drop i_am_lock[5] in LOCKED -> o_deskew_done=0, read/write enables=0 next cycle, state IDLE. Restoring lock re-measures.
- Duplicate/reset: lane3 pulses twice in COUNT -> first arrival kept. Assert i_reset mid-COUNT -> all outputs 0 next cycle, delays cleared.

Source files
------------

// File: rtl/pcs_deskew_pkg.sv
// Shared definitions for the PCS lane-deskew sequencer.
package pcs_deskew_pkg;

  localparam int DEF_N_LANES  = 20;
  localparam int DEF_MAX_SKEW = 16;

  // state | meaning
  // IDLE       | disabled or some lane out of AM lock
  // WAIT_FIRST | FIFOs filling, waiting for the earliest AM
  // COUNT      | timing the remaining lanes' AMs
  // SET        | per-lane delays presented, load strobe held
  // LOCKED     | lanes aligned, FIFOs streaming
  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRST,
    COUNT,
    SET,
    LOCKED
  } state_t;

  function automatic int delay_lsb(input int lane, input int nb);
    return lane * nb;
  endfunction

endpackage

// File: rtl/deskew_lane_capture.sv
// One lane's AM arrival time plus a seen flag; only the first arrival is kept.
module deskew_lane_capture #(
  parameter int NB_DELAY_COUNT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      capture,
  input  logic [NB_DELAY_COUNT-1:0] count,
  output logic [NB_DELAY_COUNT-1:0] arrival,
  output logic                      seen
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      arrival <= '0;
      seen    <= 1'b0;
    end else if (capture && !seen) begin
      arrival <= count;
      seen    <= 1'b1;
    end
  end

endmodule

// File: rtl/deskew_ctrl.sv
// Lane-deskew sequencer: times each lane's AM, loads per-lane FIFO delays,
// then holds the aligned state until any lane loses AM lock.
module deskew_ctrl
  import pcs_deskew_pkg::*;
#(
  parameter int N_LANES        = DEF_N_LANES,
  parameter int MAX_SKEW       = DEF_MAX_SKEW,
  parameter int NB_DELAY_COUNT = $clog2(MAX_SKEW)
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_valid,
  input  logic                              i_enable,
  input  logic [N_LANES-1:0]                i_am_lock,
  input  logic [N_LANES-1:0]                i_am_start,
  output logic                              o_fifo_write_enb,
  output logic                              o_fifo_read_enb,
  output logic                              o_set_fifo_delay,
  output logic [N_LANES*NB_DELAY_COUNT-1:0] o_fifo_delay,
  output logic                              o_deskew_done,
  output logic                              o_invalid_skew
);

  localparam logic [NB_DELAY_COUNT-1:0] COUNT_LAST = NB_DELAY_COUNT'(MAX_SKEW - 1);

  state_t                              state, state_next;
  logic [NB_DELAY_COUNT-1:0]           count, count_next;
  logic [N_LANES-1:0]                  seen;
  logic [NB_DELAY_COUNT-1:0]           arrival [N_LANES];
  logic                                abort;
  logic                                clear_capture;
  logic                                capture_window;
  logic                                all_seen;
  logic                                load_delay;
  logic [N_LANES*NB_DELAY_COUNT-1:0]   delay_next;

  genvar g;
  generate
    for (g = 0; g < N_LANES; g++) begin : g_lane
      deskew_lane_capture #(
        .NB_DELAY_COUNT(NB_DELAY_COUNT)
      ) u_capture (
        .clock  (i_clock),
        .reset  (i_reset),
        .clear  (clear_capture),
        .capture(capture_window && i_am_start[g] && !abort),
        .count  (count),
        .arrival(arrival[g]),
        .seen   (seen[g])
      );
    end
  endgenerate

  always_comb begin
    abort          = !i_enable || !(&i_am_lock);
    capture_window = i_valid && (state == WAIT_FIRST || state == COUNT);
    all_seen       = &(seen | i_am_start);
    state_next     = state;
    count_next     = count;
    clear_capture  = (state == IDLE);
    o_invalid_skew = 1'b0;

    if (abort) begin
      state_next    = IDLE;
      count_next    = '0;
      clear_capture = 1'b1;
    end else if (i_valid) begin
      case (state)
        IDLE: state_next = WAIT_FIRST;
        WAIT_FIRST: begin
          if (|i_am_start) begin
            count_next = NB_DELAY_COUNT'(1);
            state_next = (&i_am_start) ? SET : COUNT;
          end
        end
        COUNT: begin
          if (all_seen) begin
            state_next = SET;
          end else if (count == COUNT_LAST) begin
            o_invalid_skew = 1'b1;
            clear_capture  = 1'b1;
            count_next     = '0;
            state_next     = WAIT_FIRST;
          end else begin
            count_next = count + NB_DELAY_COUNT'(1);
          end
        end
        SET:     state_next = LOCKED;
        default: state_next = state;
      endcase
    end
  end

  // Delays are taken from the live count on the completing cycle; a lane
  // arriving in that same cycle is not yet seen and gets delay 0.
  always_comb begin
    delay_next = '0;
    for (int k = 0; k < N_LANES; k++) begin
      delay_next[delay_lsb(k, NB_DELAY_COUNT) +: NB_DELAY_COUNT] =
        seen[k] ? (count - arrival[k]) : '0;
    end
  end

  assign load_delay = (state_next == SET) && (state != SET);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= IDLE;
      count        <= '0;
      o_fifo_delay <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (load_delay) o_fifo_delay <= delay_next;
    end
  end

  assign o_fifo_write_enb = (state != IDLE);
  assign o_fifo_read_enb  = (state == LOCKED);
  assign o_set_fifo_delay = (state == SET);
  assign o_deskew_done    = (state == LOCKED);

endmodule

// File: tb/tb_deskew_ctrl.sv
// Directed scoreboard bench for deskew_ctrl with the default 20 lanes / 16 skew.
module tb_deskew_ctrl;

  localparam int N  = 20;
  localparam int NB = 4;
  localparam int W  = N * NB;

  typedef struct {
    logic           is_inv;
    int             cyc;
    logic [W-1:0]   dly;
  } exp_t;

  logic           i_clock = 1'b0;
  logic           i_reset;
  logic           i_valid;
  logic           i_enable;
  logic [N-1:0]   i_am_lock;
  logic [N-1:0]   i_am_start;
  logic           o_fifo_write_enb;
  logic           o_fifo_read_enb;
  logic           o_set_fifo_delay;
  logic [W-1:0]   o_fifo_delay;
  logic           o_deskew_done;
  logic           o_invalid_skew;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_set = 1'b0;

  deskew_ctrl dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_valid         (i_valid),
    .i_enable        (i_enable),
    .i_am_lock       (i_am_lock),
    .i_am_start      (i_am_start),
    .o_fifo_write_enb(o_fifo_write_enb),
    .o_fifo_read_enb (o_fifo_read_enb),
    .o_set_fifo_delay(o_set_fifo_delay),
    .o_fifo_delay    (o_fifo_delay),
    .o_deskew_done   (o_deskew_done),
    .o_invalid_skew  (o_invalid_skew)
  );

  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Lane k gets va if in mask_a, else vb if in mask_b, else vc.
  function automatic logic [W-1:0] grp(input logic [N-1:0] mask_a, input int va,
                                       input logic [N-1:0] mask_b, input int vb, input int vc);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++)
      v[k*NB +: NB] = mask_a[k] ? NB'(va) : (mask_b[k] ? NB'(vb) : NB'(vc));
    return v;
  endfunction

  task automatic step(input logic v, input logic [N-1:0] s);
    i_valid    = v;
    i_am_start = s;
    @(posedge i_clock);
    #1;
    i_am_start = '0;
  endtask

  task automatic expect_set(input logic [W-1:0] d);
    exp_t e;
    e.is_inv = 1'b0;
    e.cyc    = cyc + 1;
    e.dly    = d;
    sb.push_back(e);
  endtask

  task automatic expect_inv();
    exp_t e;
    e.is_inv = 1'b1;
    e.cyc    = cyc;
    e.dly    = '0;
    sb.push_back(e);
  endtask

  task automatic reacquire();
    i_enable = 1'b0;
    step(1'b1, '0);
    chk("idle_done", o_deskew_done, 0);
    chk("idle_wr", o_fifo_write_enb, 0);
    i_enable = 1'b1;
    step(1'b1, '0);
    chk("wait_first_wr", o_fifo_write_enb, 1);
  endtask

  always @(negedge i_clock) begin
    if (o_set_fifo_delay && !prev_set) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_set: strobe at cycle %0d, required none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("set_kind", o_invalid_skew, mon_e.is_inv);
        chk("set_latency", cyc, mon_e.cyc);
        chk("fifo_delay", o_fifo_delay, mon_e.dly);
      end
    end
    if (o_invalid_skew) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_invalid: pulse at cycle %0d, required none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("inv_kind", 1, mon_e.is_inv);
        chk("inv_cycle", cyc, mon_e.cyc);
      end
    end
    prev_set = o_set_fifo_delay;
  end

  initial begin
    logic [N-1:0] pat [8];
    i_reset = 1'b1; i_valid = 1'b0; i_enable = 1'b0; i_am_lock = '0; i_am_start = '0;
    repeat (3) @(posedge i_clock);
    #1;
    chk("rst_set", o_set_fifo_delay, 0);
    chk("rst_done", o_deskew_done, 0);
    chk("rst_wr", o_fifo_write_enb, 0);
    chk("rst_rd", o_fifo_read_enb, 0);
    chk("rst_delay", o_fifo_delay, 0);
    i_reset = 1'b0; i_enable = 1'b1; i_am_lock = '1;
    step(1'b1, '0);
    chk("s1_wait_first_wr", o_fifo_write_enb, 1);
    chk("s1_wait_first_rd", o_fifo_read_enb, 0);

    // zero skew
    expect_set('0);
    step(1'b1, '1);
    chk("s1_done_in_set", o_deskew_done, 0);
    step(1'b1, '0);
    chk("s1_done", o_deskew_done, 1);
    chk("s1_rd", o_fifo_read_enb, 1);
    chk("s1_set_dropped", o_set_fifo_delay, 0);
    step(1'b1, '1);
    chk("locked_ignores_am", o_deskew_done, 1);

    // staggered: lane0 at t, lanes1-18 at t+3, lane19 at t+7
    reacquire();
    step(1'b1, 20'h00001); step(1'b1, '0); step(1'b1, '0);
    step(1'b1, 20'h7FFFE);
    repeat (3) step(1'b1, '0);
    expect_set(grp(20'h00001, 7, 20'h7FFFE, 4, 0));
    step(1'b1, 20'h80000);
    step(1'b1, '0);
    chk("s2_done", o_deskew_done, 1);

    // overflow: lane19 never arrives, pulse at count==15
    reacquire();
    step(1'b1, 20'h7FFFF);
    repeat (14) step(1'b1, '0);
    expect_inv();
    step(1'b1, '0);
    chk("s3_inv_one_shot", o_invalid_skew, 0);
    chk("s3_back_wr", o_fifo_write_enb, 1);
    chk("s3_not_done", o_deskew_done, 0);
    step(1'b1, 20'h003FF); step(1'b1, '0);
    expect_set(grp(20'h003FF, 2, '0, 0, 0));
    step(1'b1, 20'hFFC00);
    step(1'b1, '0);
    chk("s3_done", o_deskew_done, 1);

    // staggered pattern with invalid gaps; lane3 pulse in a gap is ignored
    reacquire();
    pat = '{20'h00001, 20'h0, 20'h0, 20'h7FFFE, 20'h0, 20'h0, 20'h0, 20'h80000};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, pat[i]);
      step(1'b0, (i == 0) ? 20'h00008 : 20'h0);
    end
    expect_set(grp(20'h00001, 7, 20'h7FFFE, 4, 0));
    step(1'b1, pat[7]);
    step(1'b0, '0);
    chk("s4_set_held1", o_set_fifo_delay, 1);
    step(1'b0, '0);
    chk("s4_set_held2", o_set_fifo_delay, 1);
    chk("s4_not_done", o_deskew_done, 0);
    step(1'b1, '0);
    chk("s4_set_dropped", o_set_fifo_delay, 0);
    chk("s4_done", o_deskew_done, 1);

    // lock loss in LOCKED, taken even on an invalid cycle
    i_am_lock[5] = 1'b0;
    step(1'b0, '0);
    chk("s5_done", o_deskew_done, 0);
    chk("s5_wr", o_fifo_write_enb, 0);
    chk("s5_rd", o_fifo_read_enb, 0);
    i_am_lock = '1;
    step(1'b1, '0);
    chk("s5_rewait_wr", o_fifo_write_enb, 1);
    // duplicate pulse on lane3 keeps the first arrival
    step(1'b1, 20'h00009); step(1'b1, '0);
    step(1'b1, 20'h00008); step(1'b1, '0); step(1'b1, '0);
    expect_set(grp(20'h00009, 5, '0, 0, 0));
    step(1'b1, 20'hFFFF6);
    step(1'b1, '0);
    chk("s5_done_again", o_deskew_done, 1);

    // reset mid-COUNT
    reacquire();
    step(1'b1, 20'h00001); step(1'b1, '0);
    i_reset = 1'b1;
    step(1'b1, '0);
    chk("s6_rst_delay", o_fifo_delay, 0);
    chk("s6_rst_wr", o_fifo_write_enb, 0);
    chk("s6_rst_set", o_set_fifo_delay, 0);
    chk("s6_rst_done", o_deskew_done, 0);
    i_reset = 1'b0;
    step(1'b1, '0);
    step(1'b1, 20'hFFFFE);
    expect_set(grp(20'hFFFFE, 1, '0, 0, 0));
    step(1'b1, 20'h00001);
    step(1'b1, '0);
    chk("s6_done", o_deskew_done, 1);

    repeat (3) step(1'b1, '0);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
